// File: rtl/vram_pkg.sv
// vram_pkg: shared constants, slot type and framebuffer address helper for
// the VRAM arbiter and any later fetchers (sprites, overlays) that need the
// same display timing.
//   H_TOTAL/V_TOTAL   : full VGA frame size in pixel clocks / lines
//   H_ACTIVE/V_ACTIVE : visible area
//   LOOKAHEAD         : clocks between address issue and pixel on screen
//   CNT_W             : width of the hs/vs counters
package vram_pkg;

  localparam int CNT_W     = 10;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int LOOKAHEAD = 2;

  typedef enum logic {
    SLOT_CPU  = 1'b0,
    SLOT_DISP = 1'b1
  } slot_t;

  // Each stored pixel covers a 2x2 screen block, so both coordinates halve.
  function automatic logic [31:0] fb_addr(input logic [CNT_W-1:0] ph,
                                          input logic [CNT_W-1:0] pv,
                                          input int               fb_w);
    return 32'(pv >> 1) * 32'(fb_w) + 32'(ph >> 1);
  endfunction

endpackage

// File: rtl/vram_lookahead.sv
// vram_lookahead: maps the live VGA position (hs,vs) to the position whose
// pixel must be fetched now, LOOKAHEAD clocks ahead, and classifies the
// current memory cycle.
//   hs, vs  in  : live horizontal / vertical counters
//   ph, pv  out : lookahead position (wraps 800 -> next line, 525 -> line 0)
//   active  out : lookahead position is inside the visible area
//   slot    out : owner of this memory cycle
//
// slot      | meaning
// SLOT_DISP | even lookahead pixel in the active area: fetch for display
// SLOT_CPU  | everything else, including out-of-range hs/vs
module vram_lookahead
  import vram_pkg::*;
(
  input  logic [CNT_W-1:0] hs,
  input  logic [CNT_W-1:0] vs,
  output logic [CNT_W-1:0] ph,
  output logic [CNT_W-1:0] pv,
  output logic             active,
  output slot_t            slot
);

  logic [CNT_W:0] h_sum;
  logic           in_range;

  always_comb begin
    h_sum = {1'b0, hs} + (CNT_W+1)'(LOOKAHEAD);
    ph    = h_sum[CNT_W-1:0];
    pv    = vs;
    if (h_sum >= (CNT_W+1)'(H_TOTAL)) begin
      ph = CNT_W'(h_sum - (CNT_W+1)'(H_TOTAL));
      pv = (vs == CNT_W'(V_TOTAL - 1)) ? '0 : vs + CNT_W'(1);
    end
    // Garbage counter values must never steal a cycle from the CPU.
    in_range = (hs < CNT_W'(H_TOTAL)) && (vs < CNT_W'(V_TOTAL));
    active   = in_range && (ph < CNT_W'(H_ACTIVE)) && (pv < CNT_W'(V_ACTIVE));
    slot     = (active && !ph[0]) ? SLOT_DISP : SLOT_CPU;
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: time-shares a single-port synchronous VRAM between the
// display fetch and a CPU valid/ready port. Display reads take even
// lookahead pixels in active video; every other cycle belongs to the CPU.
//   clk_25, rst_n              : pixel clock, async active-low reset
//   hs, vs                     : VGA counters
//   cpu_req_valid/ready        : CPU handshake (ready is combinational)
//   cpu_we, cpu_addr, cpu_wdata: CPU request
//   cpu_rdata, cpu_rdata_valid : read response, one cycle after handshake
//   mem_addr/we/wdata/rdata    : RAM port (rdata one cycle after address)
//   pix_data                   : pixel for the current (hs,vs), 0 in blanking
// Optional FB_DOUBLE_BUFFER_EN: adds swap_req / front_page and a page bit on
// mem_addr; display reads the front page, the CPU accesses the back page.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17,
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int MEM_AW = ADDR_W + 1
`else
  localparam int MEM_AW = ADDR_W
`endif
) (
  input  logic              clk_25,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  hs,
  input  logic [CNT_W-1:0]  vs,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdata_valid,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef FB_DOUBLE_BUFFER_EN
  output logic [DATA_W-1:0] pix_data,
  input  logic              swap_req,
  output logic              front_page
`else
  output logic [DATA_W-1:0] pix_data
`endif
);

  logic [CNT_W-1:0]  ph, pv;
  logic              active;
  slot_t             slot;
  logic              cpu_slot, disp_go, cpu_fire, addr_ok;
  logic [ADDR_W-1:0] addr_lo;
  logic              disp_d1, active_d1;
  logic              rd_pend, rd_oor;

  vram_lookahead u_lookahead (
    .hs     (hs),
    .vs     (vs),
    .ph     (ph),
    .pv     (pv),
    .active (active),
    .slot   (slot)
  );

  // Gating with rst_n keeps every combinational output at its reset value
  // while reset is held.
  assign cpu_slot = rst_n && (slot == SLOT_CPU);
  assign disp_go  = rst_n && (slot == SLOT_DISP);
  assign cpu_fire = cpu_slot && cpu_req_valid;
  assign addr_ok  = cpu_addr < ADDR_W'(FB_W * FB_H);

  always_comb begin
    cpu_req_ready = cpu_slot;
    addr_lo       = '0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    if (disp_go) begin
      addr_lo = ADDR_W'(fb_addr(ph, pv, FB_W));
    end else if (cpu_fire) begin
      addr_lo = cpu_addr;
      // Out-of-range writes still handshake but never reach the RAM.
      if (cpu_we && addr_ok) begin
        mem_we    = 1'b1;
        mem_wdata = cpu_wdata;
      end
    end
  end

  // Two-stage pixel pipe: the cycle after a display read, mem_rdata is
  // captured; the odd-pixel cycle in between holds it so each stored pixel
  // shows twice. Leaving the active area clears the pixel.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      disp_d1   <= 1'b0;
      active_d1 <= 1'b0;
      pix_data  <= '0;
      rd_pend   <= 1'b0;
      rd_oor    <= 1'b0;
    end else begin
      disp_d1   <= (slot == SLOT_DISP);
      active_d1 <= active;
      if (disp_d1) begin
        pix_data <= mem_rdata;
      end else if (!active_d1) begin
        pix_data <= '0;
      end
      rd_pend <= cpu_fire && !cpu_we;
      rd_oor  <= !addr_ok;
    end
  end

  assign cpu_rdata_valid = rd_pend;
  assign cpu_rdata       = (rd_pend && !rd_oor) ? mem_rdata : '0;

`ifdef FB_DOUBLE_BUFFER_EN
  logic page;
  logic swap_pend;
  logic swap_now;

  assign swap_now = (hs == '0) && (vs == CNT_W'(V_ACTIVE));
  assign page     = disp_go ? front_page : (cpu_fire ? ~front_page : 1'b0);
  assign mem_addr = {page, addr_lo};

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      front_page <= 1'b0;
      swap_pend  <= 1'b0;
    end else if (swap_now) begin
      if (swap_pend || swap_req) begin
        front_page <= ~front_page;
      end
      swap_pend <= 1'b0;
    end else if (swap_req) begin
      swap_pend <= 1'b1;
    end
  end
`else
  assign mem_addr = addr_lo;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

`ifdef FB_DOUBLE_BUFFER_EN
  localparam int MEM_AW = 18;
`else
  localparam int MEM_AW = 17;
`endif

  logic              clk_25 = 1'b0;
  logic              rst_n  = 1'b0;
  logic [9:0]        hs = 10'd300, vs = 10'd100;
  logic              cpu_req_valid = 1'b0, cpu_we = 1'b0;
  logic [16:0]       cpu_addr = '0;
  logic [7:0]        cpu_wdata = '0;
  logic              cpu_req_ready, cpu_rdata_valid, mem_we;
  logic [7:0]        cpu_rdata, mem_wdata, pix_data;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        ram_q;
  logic [7:0]        ram [0:(1<<MEM_AW)-1];
  logic              ram_init = 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
  logic              swap_req = 1'b0;
  logic              front_page;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #20 clk_25 = ~clk_25;

  vram_arbiter dut (
    .clk_25          (clk_25),
    .rst_n           (rst_n),
    .hs              (hs),
    .vs              (vs),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_req_ready   (cpu_req_ready),
    .cpu_we          (cpu_we),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_rdata_valid (cpu_rdata_valid),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (ram_q),
`ifdef FB_DOUBLE_BUFFER_EN
    .pix_data        (pix_data),
    .swap_req        (swap_req),
    .front_page      (front_page)
`else
    .pix_data        (pix_data)
`endif
  );

  // RAM model: RAM[i] = i[7:0], plus a marker just past the framebuffer.
  always @(posedge clk_25) begin
    if (!ram_init) begin
      for (int i = 0; i < (1 << MEM_AW); i++) ram[i] <= 8'(i);
      ram[76800] <= 8'hEE;
      ram_init   <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      ram_q <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (hs=%0d vs=%0d)", tag, got, exp, hs, vs);
    end
  endtask

  task automatic step();
    @(posedge clk_25);
    #1;
    if (hs == 10'd799) begin
      hs = 10'd0;
      vs = (vs == 10'd524) ? 10'd0 : vs + 10'd1;
    end else begin
      hs = hs + 10'd1;
    end
  endtask

  task automatic jump(input int h, input int v);
    @(posedge clk_25);
    #1;
    hs = 10'(h);
    vs = 10'(v);
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(hs == 10'(h) && vs == 10'(v))) begin
      step();
      n++;
      if (n > 5000) begin
        chk("run_to_timeout", 32'(n), 32'd0);
        return;
      end
    end
  endtask

  task automatic smp();
    @(negedge clk_25);
  endtask

  initial begin
    // Reset held with a CPU request pending in active video.
    cpu_req_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd5; cpu_wdata = 8'hAB;
    repeat (3) step();
    smp();
    chk("rst_ready",  32'(cpu_req_ready),   0);
    chk("rst_rvalid", 32'(cpu_rdata_valid), 0);
    chk("rst_rdata",  32'(cpu_rdata),       0);
    chk("rst_we",     32'(mem_we),          0);
    chk("rst_addr",   32'(mem_addr),        0);
    chk("rst_wdata",  32'(mem_wdata),       0);
    chk("rst_pix",    32'(pix_data),        0);
    cpu_req_valid = 1'b0; cpu_we = 1'b0;

    jump(0, 0);
    rst_n = 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
    smp();
    chk("db_front_init", 32'(front_page), 0);
`endif

    // First display fetch of the frame.
    jump(790, 524);
    run_to(798, 524); smp();
    chk("first_addr",  32'(mem_addr),      0);
    chk("first_ready", 32'(cpu_req_ready), 0);
    run_to(799, 524); smp();
    chk("odd_ready",   32'(cpu_req_ready), 1);
    run_to(0, 0); smp();
    chk("addr_0_0",    32'(mem_addr),      1);
    chk("pix_0_0",     32'(pix_data),      0);
    run_to(2, 0); smp();
    chk("pix_2_0",     32'(pix_data),      1);
    run_to(3, 0); smp();
    chk("pix_3_0",     32'(pix_data),      1);

    // Mid-frame sweep and horizontal boundary.
    jump(90, 50);
    run_to(100, 50); smp(); chk("pix_100_50", 32'(pix_data), 32'h72);
    run_to(101, 50); smp(); chk("pix_101_50", 32'(pix_data), 32'h72);
    run_to(102, 50); smp(); chk("pix_102_50", 32'(pix_data), 32'h73);
    run_to(639, 50); smp(); chk("pix_639_50", 32'(pix_data), 32'h7F);
    run_to(640, 50); smp(); chk("pix_640_50", 32'(pix_data), 0);

    // Vertical boundary.
    jump(780, 478);
    run_to(0, 479); smp(); chk("pix_0_479", 32'(pix_data), 32'hC0);
    run_to(0, 480); smp(); chk("pix_0_480", 32'(pix_data), 0);

    // CPU write held valid across an active line: only odd cycles accept.
    jump(100, 10);
    cpu_req_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd5; cpu_wdata = 8'hAB;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("wr_ready", 32'(cpu_req_ready), 32'(k % 2));
      chk("wr_we",    32'(mem_we),        32'(k % 2));
      chk("wr_addr",  32'(mem_addr),      (k % 2 == 1) ? 32'd5 : 32'(1651 + k / 2));
      step();
    end
    cpu_req_valid = 1'b0; cpu_we = 1'b0;
    smp();
    chk("wr_ram5", 32'(ram[5]), 32'hAB);
    jump(0, 0);
    run_to(10, 0); smp(); chk("wr_pix_10_0", 32'(pix_data), 32'hAB);
    run_to(11, 0); smp(); chk("wr_pix_11_0", 32'(pix_data), 32'hAB);
    jump(0, 1);
    run_to(10, 1); smp(); chk("wr_pix_10_1", 32'(pix_data), 32'hAB);
    run_to(11, 1); smp(); chk("wr_pix_11_1", 32'(pix_data), 32'hAB);

    // Out-of-range hs is blanking.
    jump(900, 1); smp();
    chk("oor_hs_ready", 32'(cpu_req_ready), 1);
    step(); step(); smp();
    chk("oor_hs_pix", 32'(pix_data), 0);

    // CPU read during vertical blank.
    jump(100, 500);
    cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd8050;
    smp();
    chk("rd_ready", 32'(cpu_req_ready), 1);
    chk("rd_addr",  32'(mem_addr),      8050);
    chk("rd_we",    32'(mem_we),        0);
    step();
    cpu_req_valid = 1'b0;
    smp();
    chk("rd_valid", 32'(cpu_rdata_valid), 1);
    chk("rd_data",  32'(cpu_rdata),       32'h72);
    chk("rd_pix",   32'(pix_data),        0);
    step(); smp();
    chk("rd_valid_drop", 32'(cpu_rdata_valid), 0);

    // Out-of-range address: handshake but no write, reads return 0.
    jump(100, 490);
    cpu_req_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd76800; cpu_wdata = 8'h5A;
    smp();
    chk("oor_ready", 32'(cpu_req_ready), 1);
    chk("oor_we",    32'(mem_we),        0);
    step();
    cpu_we = 1'b0;
    smp();
    chk("oor_ram", 32'(ram[76800]), 32'hEE);
    step();
    cpu_req_valid = 1'b0;
    smp();
    chk("oor_rvalid", 32'(cpu_rdata_valid), 1);
    chk("oor_rdata",  32'(cpu_rdata),       0);

    // Reset while a read response is pending.
    jump(100, 500);
    cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd8050;
    step();
    cpu_req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(cpu_rdata_valid), 0);
    chk("mid_rst_rdata",  32'(cpu_rdata),       0);
    chk("mid_rst_ready",  32'(cpu_req_ready),   0);
    smp();
    rst_n = 1'b1;
    step(); smp();
    chk("post_rst_rvalid", 32'(cpu_rdata_valid), 0);
    chk("post_rst_ready",  32'(cpu_req_ready),   1);

`ifdef FB_DOUBLE_BUFFER_EN
    // Swap request pulse, then CPU writes before and after the flip.
    jump(0, 100);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    jump(0, 200);
    cpu_req_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd7; cpu_wdata = 8'h11;
    smp();
    chk("db_wr_before", 32'(mem_addr), 32'h20007);
    step();
    cpu_req_valid = 1'b0;
    jump(795, 479);
    run_to(0, 480); smp();
    chk("db_front_hold", 32'(front_page), 0);
    run_to(1, 480); smp();
    chk("db_front_flip", 32'(front_page), 1);
    cpu_req_valid = 1'b1;
    smp();
    chk("db_wr_after", 32'(mem_addr), 32'd7);
    step();
    cpu_req_valid = 1'b0;
    jump(798, 524); smp();
    chk("db_disp_page", 32'(mem_addr), 32'h20000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port synchronous video RAM between the display fetch path and the CPU.
- Display timing comes from the VGA counters hs/vs (800x525 total, 640x480 active, 25 MHz pixel clock).
- The framebuffer is 320x240, 8-bit; each stored pixel is shown as a 2x2 block.
- Display reads are scheduled two cycles ahead so pix_data lines up with hs/vs; every remaining memory cycle is offered to the CPU through a valid/ready handshake.

Parameters:
- DATA_W, 8, pixel/word width
- ADDR_W, 17, VRAM address width (one page; 76800 words used)
- FB_W, 320, framebuffer width in pixels
- FB_H, 240, framebuffer height in pixels

Ports:
- clk_25  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hs  in  10  horizontal counter, 0..799
- vs  in  10  vertical counter, 0..524
- cpu_req_valid  in  1  CPU request valid
- cpu_req_ready  out  1  request accepted this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  linear pixel address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data
- cpu_rdata_valid  out  1  cpu_rdata valid, one-cycle pulse
- mem_addr  out  ADDR_W(+1 with FB_DOUBLE_BUFFER_EN)  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after the address
- pix_data  out  DATA_W  pixel for current (hs,vs); 0 outside the active area

Behaviour:
- Clock and reset: single clock clk_25; rst_n asynchronous, active-low.
- Reset values: cpu_req_ready=0, cpu_rdata_valid=0, cpu_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, pix_data=0.
- Lookahead position (ph,pv) = (hs,vs) advanced by 2 pixel clocks.
  - Horizontal wraps at 800, which increments pv.
  - pv wraps at 525. Example: (799,524) -> (1,0).
- Slot decision each cycle:
  - DISP slot when ph<640, pv<480 and ph is even.
  - Otherwise CPU slot. CPU therefore owns odd cycles during active video and every cycle in blanking.
- DISP slot:
  - mem_addr = (pv>>1)*FB_W + (ph>>1), mem_we=0, cpu_req_ready=0.
  - mem_rdata is captured next cycle into pix_data, then held for the following cycle.
  - Result: pix_data is valid while (hs,vs)=(ph,ph+1 pair).
- pix_data forced to 0 by register update whenever the lookahead position is outside the active area. Latency from address issue to pix_data is exactly 2 cycles.
- CPU slot:
  - cpu_req_ready=1; handshake occurs when valid&&ready.
  - Write handshake: mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata in the same cycle.
  - Read handshake: mem_addr=cpu_addr, then cpu_rdata_valid=1 with cpu_rdata=mem_rdata on the next cycle.
  - CPU and DISP reads never overlap, because slots are exclusive per cycle.
- Out-of-range address (cpu_addr >= FB_W*FB_H): handshake still completes, but no write is issued (mem_we=0). A read returns cpu_rdata=0 with valid.
- Idle CPU slot (no valid): mem_we=0; mem_addr don't-care, driven 0.
- hs/vs values outside their ranges: treated as blanking (CPU slot).
- Reset asserted mid-transaction: pending read response is dropped and all outputs return to reset values asynchronously. After release, operation resumes from the current counters; no frame resynchronisation is needed.

Optional Feature:
- Macro: FB_DOUBLE_BUFFER_EN.
- With the macro:
  - Adds input swap_req (1) and output front_page (1), reset 0.
  - A display read uses {front_page, addr}; a CPU access uses {~front_page, cpu_addr}.
  - swap_req is sticky-latched and applied (front_page toggles, latch clears) on the cycle hs==0 && vs==480.
  - A swap_req arriving on that same cycle takes effect there.
  - mem_addr width is ADDR_W+1.
- Without the macro: single page; no swap_req or front_page ports; mem_addr is ADDR_W wide.

Decomposition:
- Package vram_pkg:
  - Constants H_TOTAL=800, V_TOTAL=525, H_ACTIVE=640, V_ACTIVE=480, LOOKAHEAD=2.
  - typedef enum {SLOT_CPU, SLOT_DISP} slot_t.
  - Function fb_addr(ph,pv).
- Sub-module vram_lookahead: combinational (hs,vs) -> (ph,pv,active,disp_slot). Reusable by later sprite or overlay fetchers.

Test Plan:
- Reset held, then released at hs=0,vs=0 -> all outputs 0 during reset. First DISP address 0 is issued at hs=798,vs=524, and pix_data=RAM[0] at hs=0,vs=0 and hs=1.
- RAM preloaded RAM[i]=i[7:0]; sweep one frame -> pix_data at (hs=100,vs=50) equals RAM[25*320+50]=RAM[8050] (0x72). Outside the active area pix_data=0.
- CPU write valid held continuously during active line vs=10, addr 5, data 0xAB -> ready only on odd hs cycles, and the write lands on a CPU slot. A later frame shows 0xAB at hs=10..11, vs=0..1.
- CPU read addr 8050 during vertical blank (vs=500) -> ready on the same cycle; cpu_rdata_valid the next cycle with 0x72; no pix_data disturbance.
- CPU write to addr 76800 -> handshake completes, mem_we stays 0, RAM unchanged; a read of 76800 returns 0.
- FB_DOUBLE_BUFFER_EN: pulse swap_req at vs=100 -> front_page toggles exactly at hs=0,vs=480. CPU writes target the other page both before and after the toggle.
